// File: rtl/pipe_arb_pkg.sv
// pipe_arb_pkg -- shared definitions for the pipe_arbiter slice.
//
// Contents:
//   arbState_e  : arbiter control states (IDLE, RUN, DRAIN, DONE)
//   idWidth()   : width of a requester index, never less than one bit
//   STATS_WIDTH : width of the optional busy-cycle counter
//
// Optional feature macro used by the slice: PIPE_ARB_STATS_EN.

package pipe_arb_pkg;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arbState_e;

  // Width of the busy-cycle statistics counter.
  localparam int STATS_WIDTH = 32;

  // Bits needed to name one of numReq requesters. A single-bit index is
  // kept even for tiny configurations so that RSP_ID is never zero width.
  function automatic int idWidth(input int numReq);
    if (numReq <= 2) begin
      return 1;
    end
    return $clog2(numReq);
  endfunction

endpackage

// File: rtl/tag_delay.sv
// tag_delay -- fixed-length shift register that carries a small tag
// alongside the shared pipeline so the tag leaves exactly NUM_STAGES
// cycles after it entered.
//
// Ports:
//   clock_i : clock, all state on the rising edge
//   reset_i : asynchronous active-high reset, clears every stage
//   tag_i   : tag entering the delay line this cycle
//   tag_o   : tag that entered NUM_STAGES cycles ago
//
// Optional feature macro: none in this file (PIPE_ARB_STATS_EN is only
// used by the top level).

module tag_delay #(
  parameter int NUM_STAGES = 2,
  parameter int WIDTH      = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] tag_i,
  output logic [WIDTH-1:0] tag_o
);

  logic [WIDTH-1:0] stage_q [NUM_STAGES];

  // Shift every stage by one each cycle. Reset wipes all stages so that
  // tags belonging to transfers in flight at reset never reappear.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // The oldest stage is the tag aligned with the pipeline output.
  assign tag_o = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/pipe_arbiter.sv
// pipe_arbiter -- round-robin arbiter feeding one shared fixed-latency
// pipeline and routing each pipeline result back to its requester.
//
// Ports:
//   CLK        : clock, all state on the rising edge
//   RESET      : asynchronous active-high reset
//   REQ_VALID  : per-requester request valid
//   REQ_DATA   : request words, requester i at slice i
//   REQ_READY  : one-hot grant, transfer when REQ_VALID[i] & REQ_READY[i]
//   PIPE_DIN   : word driven into the shared pipeline (zero when idle)
//   PIPE_DOUT  : pipeline result, NUM_STAGES cycles after PIPE_DIN
//   RSP_VALID  : response valid (no backpressure)
//   RSP_ID     : requester owning RSP_DATA
//   RSP_DATA   : pipeline result passed through
//   FLUSH      : level request to stop granting and drain
//   FLUSH_DONE : one-cycle pulse once the drain has completed
//   BUSY_CNT   : transfer-cycle counter, only present when the macro
//                PIPE_ARB_STATS_EN is defined

module pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_STAGES = 2
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [DATA_WIDTH-1:0]         PIPE_DIN,
  input  logic [DATA_WIDTH-1:0]         PIPE_DOUT,
  output logic                          RSP_VALID,
  output logic [idWidth(NUM_REQ)-1:0]   RSP_ID,
  output logic [DATA_WIDTH-1:0]         RSP_DATA,
  input  logic                          FLUSH,
  output logic                          FLUSH_DONE
`ifdef PIPE_ARB_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]        BUSY_CNT
`endif
);

  localparam int IdW  = idWidth(NUM_REQ);
  localparam int CntW = $clog2(NUM_STAGES + 1);

  arbState_e         state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]   inflight_q, inflight_d;

  logic [NUM_REQ-1:0] grantVec;
  logic [IdW-1:0]     grantIdx;
  logic [IdW-1:0]     candIdx;
  logic               xfer;
  logic [IdW:0]       tagIn;
  logic [IdW:0]       tagOut;
  logic               rspValid;

  // Round-robin search, only while running. The search starts at ptr_q,
  // which always names the requester after the last one that actually
  // transferred. Since only valid requesters are picked, a grant is
  // always a completed transfer.
  always_comb begin
    grantVec = '0;
    grantIdx = '0;
    candIdx  = '0;
    xfer     = 1'b0;
    if (state_q == RUN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        candIdx = IdW'((int'(ptr_q) + k) % NUM_REQ);
        if (!xfer && REQ_VALID[candIdx]) begin
          xfer     = 1'b1;
          grantIdx = candIdx;
        end
      end
      if (xfer) begin
        grantVec[grantIdx] = 1'b1;
      end
    end
  end

  assign REQ_READY = grantVec;

  // Steer the granted word into the pipeline; zeros when nothing moves.
  always_comb begin
    PIPE_DIN = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantVec[i]) begin
        PIPE_DIN = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The {valid, id} tag travels beside the data so that the response
  // owner lines up with PIPE_DOUT. Idle cycles insert an all-zero tag,
  // which keeps RSP_ID at zero whenever RSP_VALID is low.
  assign tagIn = {xfer, grantIdx};

  tag_delay #(
    .NUM_STAGES (NUM_STAGES),
    .WIDTH      (IdW + 1)
  ) u_tagDelay (
    .clock_i (CLK),
    .reset_i (RESET),
    .tag_i   (tagIn),
    .tag_o   (tagOut)
  );

  assign rspValid  = tagOut[IdW];
  assign RSP_VALID = rspValid;
  assign RSP_ID    = tagOut[IdW-1:0];
  assign RSP_DATA  = PIPE_DOUT;

  // Pointer moves past the winner only when a word really moved; the
  // in-flight count tracks words inside the pipeline and nets out when a
  // transfer and a response happen in the same cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (grantIdx == IdW'(NUM_REQ - 1)) ? '0 : grantIdx + IdW'(1);
    end
    inflight_d = inflight_q;
    if (xfer && !rspValid) begin
      inflight_d = inflight_q + CntW'(1);
    end else if (!xfer && rspValid) begin
      inflight_d = inflight_q - CntW'(1);
    end
  end

  // Control FSM. FLUSH keeps an idle arbiter idle rather than starting
  // it. DRAIN looks at the next-cycle count so DONE follows the final
  // response by exactly one cycle.
  always_comb begin
    state_d    = state_q;
    FLUSH_DONE = 1'b0;
    case (state_q)
      IDLE: begin
        if (!FLUSH && (|REQ_VALID)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (FLUSH) begin
          state_d = DRAIN;
        end else if (!(|REQ_VALID) && (inflight_q == '0)) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (inflight_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        FLUSH_DONE = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers: state, round-robin pointer and in-flight count
  // all clear together on reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef PIPE_ARB_STATS_EN
  logic [STATS_WIDTH-1:0] busyCnt_q, busyCnt_d;

  // Busy-cycle counter: counts transfer cycles, holds at all-ones, and
  // is cleared as the arbiter passes through DONE.
  always_comb begin
    busyCnt_d = busyCnt_q;
    if (state_q == DONE) begin
      busyCnt_d = '0;
    end else if (xfer && (busyCnt_q != '1)) begin
      busyCnt_d = busyCnt_q + STATS_WIDTH'(1);
    end
  end

  // Busy-cycle counter register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busyCnt_q <= '0;
    end else begin
      busyCnt_q <= busyCnt_d;
    end
  end

  assign BUSY_CNT = busyCnt_q;
`else
  // Statistics disabled: no counter hardware in this build.
`endif

endmodule

// File: tb/tb_pipe_arbiter.sv
// tb_pipe_arbiter -- directed bench for pipe_arbiter.
// Instance A uses 2 pipeline stages, instance B uses 1. The shared
// pipeline is modelled here as a register chain that XORs each word with
// a fixed key, so response data differs from request data.
// Optional feature macro exercised when defined: PIPE_ARB_STATS_EN.

module tb_pipe_arbiter;

  localparam logic [15:0] XOR_KEY = 16'h5A5A;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [63:0] reqData = {16'h3333, 16'h2222, 16'h1111, 16'h00A5};

  logic        rstA = 1'b1;
  logic        flushA = 1'b0;
  logic [3:0]  validA = 4'b0000;
  logic [3:0]  readyA;
  logic [15:0] pipeDinA, pipeDoutA, rspDataA;
  logic        rspValidA, flushDoneA;
  logic [1:0]  rspIdA;
  logic [15:0] pipeA1, pipeA2;

  logic        rstB = 1'b1;
  logic        flushB = 1'b0;
  logic [3:0]  validB = 4'b0000;
  logic [3:0]  readyB;
  logic [15:0] pipeDinB, pipeDoutB, rspDataB;
  logic        rspValidB, flushDoneB;
  logic [1:0]  rspIdB;
  logic [15:0] pipeB1;

`ifdef PIPE_ARB_STATS_EN
  logic [31:0] busyCntA, busyCntB;
`endif

  // External pipeline models: two stages for A, one stage for B.
  always @(posedge clock) begin
    pipeA1 <= pipeDinA ^ XOR_KEY;
    pipeA2 <= pipeA1;
    pipeB1 <= pipeDinB ^ XOR_KEY;
  end
  assign pipeDoutA = pipeA2;
  assign pipeDoutB = pipeB1;

  pipe_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .NUM_STAGES(2)) dutA (
    .CLK(clock), .RESET(rstA), .REQ_VALID(validA), .REQ_DATA(reqData),
    .REQ_READY(readyA), .PIPE_DIN(pipeDinA), .PIPE_DOUT(pipeDoutA),
    .RSP_VALID(rspValidA), .RSP_ID(rspIdA), .RSP_DATA(rspDataA),
    .FLUSH(flushA), .FLUSH_DONE(flushDoneA)
`ifdef PIPE_ARB_STATS_EN
    , .BUSY_CNT(busyCntA)
`endif
  );

  pipe_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .NUM_STAGES(1)) dutB (
    .CLK(clock), .RESET(rstB), .REQ_VALID(validB), .REQ_DATA(reqData),
    .REQ_READY(readyB), .PIPE_DIN(pipeDinB), .PIPE_DOUT(pipeDoutB),
    .RSP_VALID(rspValidB), .RSP_ID(rspIdB), .RSP_DATA(rspDataB),
    .FLUSH(flushB), .FLUSH_DONE(flushDoneB)
`ifdef PIPE_ARB_STATS_EN
    , .BUSY_CNT(busyCntB)
`endif
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  expReady;
    logic        expRspValid;
    logic [1:0]  expRspId;
    logic [15:0] expRspData;
  } vec_t;

  localparam int NROWS = 20;
  vec_t vecs [NROWS];

  function automatic vec_t mkVec(input logic rst, input logic [3:0] valid,
                                 input logic [3:0] ready, input logic rv,
                                 input logic [1:0] id, input logic [15:0] data);
    vec_t v;
    v.rst = rst; v.valid = valid; v.expReady = ready;
    v.expRspValid = rv; v.expRspId = id; v.expRspData = data;
    return v;
  endfunction

  // Word expected on PIPE_DIN for a given one-hot grant.
  function automatic logic [15:0] dataFor(input logic [3:0] g);
    case (g)
      4'b0001: return 16'h00A5;
      4'b0010: return 16'h1111;
      4'b0100: return 16'h2222;
      4'b1000: return 16'h3333;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rstA   = v.rst;
    validA = v.valid;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int rspSeen, doneSeen, lastRsp, doneAt, cnt;

    // Reset/single request, then 4-way round-robin after a fresh reset.
    vecs[0]  = mkVec(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000);
    vecs[1]  = mkVec(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000);
    vecs[2]  = mkVec(1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0, 16'h0000);
    vecs[3]  = mkVec(1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0, 16'h0000);
    vecs[4]  = mkVec(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000);
    vecs[5]  = mkVec(1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 16'h5AFF);
    vecs[6]  = mkVec(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000);
    vecs[7]  = mkVec(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000);
    vecs[8]  = mkVec(1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 16'h0000);
    vecs[9]  = mkVec(1'b0, 4'b1111, 4'b0001, 1'b0, 2'd0, 16'h0000);
    vecs[10] = mkVec(1'b0, 4'b1111, 4'b0010, 1'b0, 2'd0, 16'h0000);
    vecs[11] = mkVec(1'b0, 4'b1111, 4'b0100, 1'b1, 2'd0, 16'h5AFF);
    vecs[12] = mkVec(1'b0, 4'b1111, 4'b1000, 1'b1, 2'd1, 16'h4B4B);
    vecs[13] = mkVec(1'b0, 4'b1111, 4'b0001, 1'b1, 2'd2, 16'h7878);
    vecs[14] = mkVec(1'b0, 4'b1111, 4'b0010, 1'b1, 2'd3, 16'h6969);
    vecs[15] = mkVec(1'b0, 4'b1111, 4'b0100, 1'b1, 2'd0, 16'h5AFF);
    vecs[16] = mkVec(1'b0, 4'b1111, 4'b1000, 1'b1, 2'd1, 16'h4B4B);
    vecs[17] = mkVec(1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 16'h7878);
    vecs[18] = mkVec(1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, 16'h6969);
    vecs[19] = mkVec(1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000);

    nextCycle();

    for (int r = 0; r < NROWS; r++) begin
      applyStimulus(vecs[r]);
      @(negedge clock);
      checkOutput($sformatf("row%0d.ready", r), 32'(readyA), 32'(vecs[r].expReady));
      checkOutput($sformatf("row%0d.pipeDin", r), 32'(pipeDinA), 32'(dataFor(vecs[r].expReady)));
      checkOutput($sformatf("row%0d.rspValid", r), 32'(rspValidA), 32'(vecs[r].expRspValid));
      checkOutput($sformatf("row%0d.flushDone", r), 32'(flushDoneA), 32'd0);
      if (vecs[r].expRspValid) begin
        checkOutput($sformatf("row%0d.rspId", r), 32'(rspIdA), 32'(vecs[r].expRspId));
        checkOutput($sformatf("row%0d.rspData", r), 32'(rspDataA), 32'(vecs[r].expRspData));
      end
      if (vecs[r].rst) begin
        checkOutput($sformatf("row%0d.rspIdRst", r), 32'(rspIdA), 32'd0);
      end
      nextCycle();
    end

    // Flush with two transfers in flight (second transfer coincides with FLUSH).
    validA = 4'b0011;
    @(negedge clock); checkOutput("flush.idle", 32'(readyA), 32'b0000); nextCycle();
    @(negedge clock); checkOutput("flush.grant0", 32'(readyA), 32'b0001); nextCycle();
    flushA = 1'b1;
    @(negedge clock); checkOutput("flush.grant1", 32'(readyA), 32'b0010); nextCycle();
    rspSeen = 0; doneSeen = 0; lastRsp = -1; doneAt = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      checkOutput($sformatf("flush.noGrant%0d", c), 32'(readyA), 32'd0);
      if (rspValidA) begin
        checkOutput($sformatf("flush.rspId%0d", rspSeen), 32'(rspIdA), 32'(rspSeen));
        checkOutput($sformatf("flush.rspData%0d", rspSeen), 32'(rspDataA),
                    (rspSeen == 0) ? 32'h5AFF : 32'h4B4B);
        lastRsp = c;
        rspSeen++;
      end
      if (flushDoneA) begin
        doneSeen++;
        doneAt = c;
        flushA = 1'b0;
      end
      validA = 4'b0000;
      nextCycle();
    end
    flushA = 1'b0;
    checkOutput("flush.rspCount", 32'(rspSeen), 32'd2);
    checkOutput("flush.doneCount", 32'(doneSeen), 32'd1);
    checkOutput("flush.doneTiming", 32'(doneAt), 32'(lastRsp + 1));

    // Reset asserted with two transfers in flight.
    validA = 4'b0001;
    @(negedge clock); checkOutput("rstMid.idle", 32'(readyA), 32'b0000); nextCycle();
    @(negedge clock); checkOutput("rstMid.grant0", 32'(readyA), 32'b0001); nextCycle();
    @(negedge clock); checkOutput("rstMid.grant1", 32'(readyA), 32'b0001); nextCycle();
    rstA = 1'b1;
    #1;
    checkOutput("rstMid.ready", 32'(readyA), 32'd0);
    checkOutput("rstMid.pipeDin", 32'(pipeDinA), 32'd0);
    checkOutput("rstMid.rspValid", 32'(rspValidA), 32'd0);
    checkOutput("rstMid.rspId", 32'(rspIdA), 32'd0);
    checkOutput("rstMid.flushDone", 32'(flushDoneA), 32'd0);
    nextCycle();
    rstA = 1'b0;
    validA = 4'b0000;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (rspValidA) cnt++;
      nextCycle();
    end
    checkOutput("rstMid.staleRsp", 32'(cnt), 32'd0);

`ifdef PIPE_ARB_STATS_EN
    // Busy counter: five transfers, then flush clears it via DONE.
    @(negedge clock); checkOutput("stats.initial", busyCntA, 32'd0);
    validA = 4'b0001;
    nextCycle();
    for (int c = 0; c < 5; c++) nextCycle();
    validA = 4'b0000;
    flushA = 1'b1;
    @(negedge clock); checkOutput("stats.count", busyCntA, 32'd5);
    doneSeen = 0;
    for (int c = 0; c < 8 && doneSeen == 0; c++) begin
      nextCycle();
      @(negedge clock);
      if (flushDoneA) doneSeen = 1;
    end
    checkOutput("stats.doneSeen", 32'(doneSeen), 32'd1);
    flushA = 1'b0;
    nextCycle();
    @(negedge clock); checkOutput("stats.cleared", busyCntA, 32'd0);
    nextCycle();
`endif

    // Single-stage instance, requester 2 alone: full throughput, id 2.
    @(negedge clock);
    checkOutput("b.rstReady", 32'(readyB), 32'd0);
    checkOutput("b.rstRspValid", 32'(rspValidB), 32'd0);
    nextCycle();
    rstB = 1'b0;
    validB = 4'b0100;
    @(negedge clock); checkOutput("b.idle", 32'(readyB), 32'd0); nextCycle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checkOutput($sformatf("b.ready%0d", k), 32'(readyB), 32'b0100);
      checkOutput($sformatf("b.pipeDin%0d", k), 32'(pipeDinB), 32'h2222);
      checkOutput($sformatf("b.rspValid%0d", k), 32'(rspValidB), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        checkOutput($sformatf("b.rspId%0d", k), 32'(rspIdB), 32'd2);
        checkOutput($sformatf("b.rspData%0d", k), 32'(rspDataB), 32'h7878);
      end
      nextCycle();
    end
    validB = 4'b0000;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (rspValidB) cnt++;
      nextCycle();
    end
    checkOutput("b.tailRsp", 32'(cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_arbiter.md
PIPE_ARBITER -- requirements
Module: pipe_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one fixed-latency pipeline (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of one request/response word.
REQ-003 SHALL have parameter NUM_STAGES, default 2, latency in cycles of the shared pipeline (1..8).
REQ-004 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port REQ_VALID  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port REQ_DATA  input  NUM_REQ*DATA_WIDTH  request words; requester i at slice i.
REQ-008 SHALL have port REQ_READY  output  NUM_REQ  one-hot grant; transfer when REQ_VALID[i]&REQ_READY[i].
REQ-009 SHALL have port PIPE_DIN  output  DATA_WIDTH  word driven into the shared pipeline.
REQ-010 SHALL have port PIPE_DOUT  input  DATA_WIDTH  pipeline output, NUM_STAGES cycles after PIPE_DIN.
REQ-011 SHALL have port RSP_VALID  output  1  response valid; no backpressure.
REQ-012 SHALL have port RSP_ID  output  log2(NUM_REQ), min 1  index of the requester owning RSP_DATA.
REQ-013 SHALL have port RSP_DATA  output  DATA_WIDTH  equals PIPE_DOUT.
REQ-014 SHALL have port FLUSH  input  1  level request to stop granting and drain.
REQ-015 SHALL have port FLUSH_DONE  output  1  one-cycle pulse when the drain completes.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE; reset to IDLE.
REQ-017 SHALL move IDLE->RUN when any REQ_VALID is high and FLUSH is low; FLUSH takes priority over requests in IDLE, RUN->DRAIN on FLUSH.
REQ-018 SHALL move DRAIN->DONE when in-flight count is 0, DONE->IDLE unconditionally after one cycle; FLUSH_DONE high only in DONE.
REQ-019 SHALL grant combinationally in RUN only: at most one REQ_READY bit per cycle, round-robin starting from the requester after the last granted one.
REQ-020 SHALL advance the round-robin pointer only on a completed transfer; pointer resets to requester 0.
REQ-021 SHALL drive PIPE_DIN with the granted REQ_DATA slice, else all zeros.
REQ-022 SHALL carry {valid, id} through a NUM_STAGES delay line so RSP_VALID/RSP_ID align exactly with PIPE_DOUT; latency transfer->response is exactly NUM_STAGES cycles.
REQ-023 SHALL keep an in-flight counter (0..NUM_STAGES): +1 on transfer, -1 on RSP_VALID, unchanged on simultaneous both.
REQ-024 SHALL, in RUN with no REQ_VALID and in-flight 0, return to IDLE.
REQ-025 SHALL, with a single requester continuously valid, grant it every cycle (100% throughput).

Reset
REQ-026 SHALL on RESET clear state, pointer, counter and delay line asynchronously: REQ_READY=0, RSP_VALID=0, RSP_ID=0, FLUSH_DONE=0, PIPE_DIN=0.
REQ-027 SHALL discard all in-flight tags on RESET mid-operation; no response is emitted for them.

Configuration
REQ-028 SHALL, when PIPE_ARB_STATS_EN is defined, add output BUSY_CNT (32 bits) counting cycles with a transfer, saturating at all-ones, cleared by RESET and in DONE.
REQ-029 SHALL, without PIPE_ARB_STATS_EN, have no BUSY_CNT port and no counter logic.

Structure
REQ-030 SHALL place the state encoding (IDLE/RUN/DRAIN/DONE) and the id-width function in shared package pipe_arb_pkg.
REQ-031 SHALL implement the {valid,id} delay line as sub-module tag_delay with async reset, parameterised by NUM_STAGES and width.

Verification
REQ-032 SHALL cover: reset, REQ_VALID=4'b0001, REQ_DATA[0]=16'h00A5 -> REQ_READY=0001, RSP_VALID/RSP_ID=0/RSP_DATA=PIPE_DOUT exactly 2 cycles later.
REQ-033 SHALL cover: REQ_VALID=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle.
REQ-034 SHALL cover: FLUSH while 2 transfers in flight -> REQ_READY=0 next cycle, 2 responses delivered, FLUSH_DONE pulses once 1 cycle after the last response.
REQ-035 SHALL cover: RESET asserted with 2 in flight -> outputs 0 immediately, no RSP_VALID after release.
REQ-036 SHALL cover: NUM_STAGES=1, requester 2 only valid -> RSP_ID=2 one cycle after each transfer, in-flight never exceeds 1.
REQ-037 SHALL cover: PIPE_ARB_STATS_EN defined, 5 transfers -> BUSY_CNT=5, returns to 0 after FLUSH_DONE.
